// File: rtl/volt_pkg.sv
// ============================================================================
// Module : volt_pkg
// Brief  : Shared code width, default legal window and FSM state encoding
//          for the voltage ramp controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package volt_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] V_MIN_DEF = 4'd5;
  localparam logic [CODE_W-1:0] V_MAX_DEF = 4'd10;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RAMP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_IDLE   = 2'd3
  } state_t;

  // Counter width for a modulus-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/voltage_ramp_controller_if.sv
// ============================================================================
// Module : voltage_ramp_controller_if
// Brief  : Setpoint request handshake between supervisor and ramp controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface voltage_ramp_controller_if;
  import volt_pkg::*;

  logic              req_valid;
  logic [CODE_W-1:0] req_volt;
  logic              req_ready;

  modport master (output req_valid, output req_volt, input req_ready);
  modport slave  (input req_valid, input req_volt, output req_ready);

endinterface

`default_nettype wire

// File: rtl/volt_clamp.sv
// ============================================================================
// Module : volt_clamp
// Brief  : Combinational clamp of a supply code into [V_MIN, V_MAX].
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module volt_clamp
  import volt_pkg::*;
#(
  parameter logic [CODE_W-1:0] V_MIN = V_MIN_DEF,
  parameter logic [CODE_W-1:0] V_MAX = V_MAX_DEF
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [CODE_W-1:0] o_code
);

  always_comb begin
    o_code = i_code;
    if (i_code < V_MIN) begin
      o_code = V_MIN;
    end else if (i_code > V_MAX) begin
      o_code = V_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/voltage_ramp_controller.sv
// ============================================================================
// Module : voltage_ramp_controller
// Brief  : Steps the regulated supply code one LSB per STEP_DIV cycles toward
//          a clamped setpoint, settles, then pulses done.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voltage_ramp_controller
  import volt_pkg::*;
#(
  parameter int                STEP_DIV   = 4,
  parameter int                SETTLE_CYC = 2,
  parameter logic [CODE_W-1:0] V_MIN      = V_MIN_DEF,
  parameter logic [CODE_W-1:0] V_MAX      = V_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  voltage_ramp_controller_if.slave req,
  output logic [CODE_W-1:0]        op_volt,
  output logic [CODE_W-1:0]        target,
  output logic                     busy,
  output logic                     done
);

  localparam int PRE_W = cnt_width(STEP_DIV);
  localparam int SET_W = cnt_width(SETTLE_CYC);

  localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [SET_W-1:0] c_SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PRE_W-1:0]  r_pre;
  logic [PRE_W-1:0]  w_pre_nxt;
  logic [SET_W-1:0]  r_set;
  logic [SET_W-1:0]  w_set_nxt;
  logic [CODE_W-1:0] r_op;
  logic [CODE_W-1:0] w_op_nxt;
  logic [CODE_W-1:0] r_tgt;
  logic [CODE_W-1:0] w_tgt_nxt;
  logic [CODE_W-1:0] w_step;
  logic [CODE_W-1:0] w_clamped;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;

  volt_clamp #(
    .V_MIN (V_MIN),
    .V_MAX (V_MAX)
  ) u_clamp (
    .i_code (req.req_volt),
    .o_code (w_clamped)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_pre   <= '0;
      r_set   <= '0;
      r_op    <= '0;
      r_tgt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_set   <= w_set_nxt;
      r_op    <= w_op_nxt;
      r_tgt   <= w_tgt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_set_nxt   = r_set;
    w_op_nxt    = r_op;
    w_tgt_nxt   = r_tgt;
    w_done_nxt  = 1'b0;
    w_step      = (r_tgt > r_op) ? r_op + 4'd1 : r_op - 4'd1;

    // Dropping enable abandons any ramp or settle without a done pulse.
    if (!en) begin
      w_state_nxt = ST_OFF;
      w_op_nxt    = '0;
      w_pre_nxt   = '0;
      w_set_nxt   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_SETTLE;
          w_op_nxt    = V_MIN;
          w_tgt_nxt   = V_MIN;
          w_set_nxt   = '0;
        end
        ST_IDLE: begin
          if (req.req_valid) begin
            w_tgt_nxt = w_clamped;
            if (w_clamped != r_op) begin
              w_state_nxt = ST_RAMP;
              w_pre_nxt   = '0;
            end else begin
              w_state_nxt = ST_SETTLE;
              w_set_nxt   = '0;
            end
          end
        end
        ST_RAMP: begin
          if (r_pre == c_PRE_LAST) begin
            w_pre_nxt = '0;
            w_op_nxt  = w_step;
            if (w_step == r_tgt) begin
              w_state_nxt = ST_SETTLE;
              w_set_nxt   = '0;
            end
          end else begin
            w_pre_nxt = r_pre + PRE_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_set == c_SET_LAST) begin
            w_state_nxt = ST_IDLE;
            w_set_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_set_nxt = r_set + SET_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_SETTLE);
  end

  assign req.req_ready = (r_state == ST_IDLE) && en;
  assign op_volt       = r_op;
  assign target        = r_tgt;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_voltage_ramp_controller.sv
// ============================================================================
// Module : tb_voltage_ramp_controller
// Brief  : Directed bench with a trajectory model of the ramp controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voltage_ramp_controller;

  localparam int STEP_DIV   = 4;
  localparam int SETTLE_CYC = 2;
  localparam int V_MIN      = 5;
  localparam int V_MAX      = 10;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] op_volt;
  logic [3:0] target;
  logic       busy;
  logic       done;

  voltage_ramp_controller_if bus ();

  voltage_ramp_controller #(
    .STEP_DIV   (STEP_DIV),
    .SETTLE_CYC (SETTLE_CYC),
    .V_MIN      (4'(V_MIN)),
    .V_MAX      (4'(V_MAX))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (bus.slave),
    .op_volt (op_volt),
    .target  (target),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the supply follows a straight-line trajectory from m_start to
  // m_tgt launched at edge m_ev; everything is a function of elapsed edges.
  int cyc    = 0;
  bit m_on   = 1'b0;
  int m_ev   = 0;
  int m_start = 0;
  int m_tgt  = 0;
  int m_tout = 0;

  function automatic int clampv(input int v);
    if (v < V_MIN) return V_MIN;
    if (v > V_MAX) return V_MAX;
    return v;
  endfunction

  function automatic int m_dist();
    return (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
  endfunction

  function automatic int m_lat();
    return STEP_DIV * m_dist() + SETTLE_CYC;
  endfunction

  function automatic int m_op(input int c);
    int steps;
    if (!m_on) return 0;
    steps = (c - m_ev) / STEP_DIV;
    if (steps > m_dist()) steps = m_dist();
    return (m_tgt >= m_start) ? m_start + steps : m_start - steps;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    int  cur;
    int  t;
    bit  rdy;
    @(posedge clk);
    cur = m_op(cyc);
    rdy = m_on && ((cyc - m_ev) >= m_lat());
    cyc++;
    if (!rst_n) begin
      m_on   = 1'b0;
      m_tout = 0;
    end else if (!en) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      m_on    = 1'b1;
      m_ev    = cyc;
      m_start = V_MIN;
      m_tgt   = V_MIN;
      m_tout  = V_MIN;
    end else if (rdy && bus.req_valid) begin
      m_start = cur;
      m_tgt   = clampv(int'(bus.req_volt));
      m_tout  = m_tgt;
      m_ev    = cyc;
    end
    #1;
    t = cyc - m_ev;
    check("op_volt", 8'(op_volt), 8'(m_op(cyc)));
    check("target",  8'(target),  8'(m_tout));
    check("busy",    8'(busy),    8'(m_on && (t < m_lat())));
    check("done",    8'(done),    8'(m_on && (t == m_lat())));
    check("req_ready", 8'(bus.req_ready), 8'(m_on && (t >= m_lat()) && en));
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req_xfer(input logic [3:0] v);
    bus.req_valid = 1'b1;
    bus.req_volt  = v;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_until_done(input int max);
    for (int i = 0; i < max && done !== 1'b1; i++) tick();
    check("done_seen", 8'(done), 8'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_volt  = 4'd0;

    // Reset and soft start
    ticks(3);
    check("lit_reset_op", 8'(op_volt), 8'd0);
    rst_n = 1'b1;
    tick();
    check("lit_soft_op", 8'(op_volt), 8'd5);
    check("lit_soft_tgt", 8'(target), 8'd5);
    ticks(2);
    check("lit_soft_done", 8'(done), 8'd1);

    // Ramp up 5 -> 8, back-to-back with the done cycle
    req_xfer(4'd8);
    ticks(4);
    check("lit_up_6", 8'(op_volt), 8'd6);
    ticks(4);
    check("lit_up_7", 8'(op_volt), 8'd7);
    ticks(4);
    check("lit_up_8", 8'(op_volt), 8'd8);
    ticks(2);
    check("lit_up_done", 8'(done), 8'd1);

    // Clamp at both ends
    req_xfer(4'd15);
    check("lit_clamp_hi", 8'(target), 8'd10);
    run_until_done(40);
    check("lit_hi_op", 8'(op_volt), 8'd10);
    req_xfer(4'd0);
    check("lit_clamp_lo", 8'(target), 8'd5);
    run_until_done(40);
    check("lit_lo_op", 8'(op_volt), 8'd5);

    // Zero-delta request
    req_xfer(4'd5);
    ticks(2);
    check("lit_zero_done", 8'(done), 8'd1);
    check("lit_zero_op", 8'(op_volt), 8'd5);

    // Request held during a ramp is ignored
    req_xfer(4'd7);
    bus.req_valid = 1'b1;
    bus.req_volt  = 4'd12;
    ticks(6);
    bus.req_valid = 1'b0;
    check("lit_ignore_tgt", 8'(target), 8'd7);
    run_until_done(20);
    check("lit_ignore_op", 8'(op_volt), 8'd7);

    // Enable drop mid-ramp 5 -> 9 at op_volt 7
    req_xfer(4'd5);
    run_until_done(20);
    req_xfer(4'd9);
    ticks(8);
    check("lit_en_pre", 8'(op_volt), 8'd7);
    en = 1'b0;
    tick();
    check("lit_en_op", 8'(op_volt), 8'd0);
    check("lit_en_done", 8'(done), 8'd0);
    ticks(3);
    en = 1'b1;
    tick();
    check("lit_en_soft", 8'(op_volt), 8'd5);
    run_until_done(10);

    // Reset mid-ramp at op_volt 8
    req_xfer(4'd9);
    ticks(12);
    check("lit_rst_pre", 8'(op_volt), 8'd8);
    rst_n = 1'b0;
    tick();
    check("lit_rst_op", 8'(op_volt), 8'd0);
    check("lit_rst_tgt", 8'(target), 8'd0);
    check("lit_rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;
    tick();
    check("lit_rst_soft", 8'(op_volt), 8'd5);
    run_until_done(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
